// File: rtl/dmc_pkg.sv
// Shared types and address-decode helpers for the data memory controller.
package dmc_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [WORD_W-1:0] word_index(
    input logic [WORD_W-1:0] addr,
    input logic [WORD_W-1:0] base
  );
    return (addr - base) >> BYTE_OFF_W;
  endfunction

  // Below-base addresses wrap to a huge index, but are flagged explicitly anyway.
  function automatic logic addr_error(
    input logic [WORD_W-1:0] addr,
    input logic [WORD_W-1:0] base,
    input int unsigned       depth
  );
    logic [WORD_W-1:0] idx;
    idx = word_index(addr, base);
    return (addr[BYTE_OFF_W-1:0] != '0) || (addr < base) || (idx >= depth);
  endfunction

endpackage

// File: rtl/word_sram.sv
// Single-port word SRAM with registered read; read data holds between reads.
module word_sram
  import dmc_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory_controller.sv
// Single-outstanding data memory port with configurable wait states and
// request validation in front of a word SRAM.
module data_memory_controller
  import dmc_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_addr,
  input  logic        memory_rden,
  input  logic        memory_wren,
  input  logic [31:0] memory_write_val,
  output logic [31:0] memory_read_val,
  output logic        memory_response,
  output logic        memory_error
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [AW-1:0]     req_index;
  logic [WORD_W-1:0] req_wdata;
  logic              req_rd;
  logic              req_wr;
  logic              req_err;
  logic              rd_valid;

  logic              req_in;
  logic              in_err;
  logic [AW-1:0]     in_index;
  logic              enter_resp;
  logic              sel_rd;
  logic              sel_wr;
  logic              sel_err;
  logic [AW-1:0]     sel_index;
  logic [WORD_W-1:0] sel_wdata;
  logic              sram_en;
  logic [WORD_W-1:0] sram_rdata;

  // With zero wait states the array is accessed on the capture edge itself,
  // so the live inputs feed the SRAM instead of the captured copy.
  always_comb begin
    req_in     = memory_rden | memory_wren;
    in_err     = addr_error(memory_addr, BASE_ADDR, DEPTH_WORDS) | (memory_rden & memory_wren);
    in_index   = AW'(word_index(memory_addr, BASE_ADDR));
    enter_resp = 1'b0;
    sel_rd     = req_rd;
    sel_wr     = req_wr;
    sel_err    = req_err;
    sel_index  = req_index;
    sel_wdata  = req_wdata;
    if (state == IDLE) begin
      sel_rd     = memory_rden;
      sel_wr     = memory_wren;
      sel_err    = in_err;
      sel_index  = in_index;
      sel_wdata  = memory_write_val;
      enter_resp = req_in && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_resp = (cnt == '0);
    end
  end

  assign sram_en = enter_resp & ~sel_err & reset;

  word_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sel_wr),
    .addr (sel_index),
    .wdata(sel_wdata),
    .rdata(sram_rdata)
  );

  assign memory_read_val = rd_valid ? sram_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      req_index       <= '0;
      req_wdata       <= '0;
      req_rd          <= 1'b0;
      req_wr          <= 1'b0;
      req_err         <= 1'b0;
      rd_valid        <= 1'b0;
      memory_response <= 1'b0;
      memory_error    <= 1'b0;
    end else begin
      memory_response <= enter_resp;
      memory_error    <= enter_resp & sel_err;
      if (enter_resp) begin
        rd_valid <= sel_rd & ~sel_err;
      end
      unique case (state)
        IDLE: begin
          if (req_in) begin
            req_index <= in_index;
            req_wdata <= memory_write_val;
            req_rd    <= memory_rden;
            req_wr    <= memory_wren;
            req_err   <= in_err;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Self-checking bench: two controller instances (2 and 0 wait states), vector
// table, hand-written corner sequences and randomized traffic against a model.
module tb_data_memory_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_addr = '0, a_wval = '0, a_rval;
  logic        a_rden = 1'b0, a_wren = 1'b0, a_resp, a_err;
  logic [31:0] b_addr = '0, b_wval = '0, b_rval;
  logic        b_rden = 1'b0, b_wren = 1'b0, b_resp, b_err;

  data_memory_controller #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(2),
    .BASE_ADDR  (32'h0000_0000)
  ) dut_a (
    .clk(clk), .reset(reset), .memory_addr(a_addr), .memory_rden(a_rden),
    .memory_wren(a_wren), .memory_write_val(a_wval), .memory_read_val(a_rval),
    .memory_response(a_resp), .memory_error(a_err)
  );

  data_memory_controller #(
    .DEPTH_WORDS(16),
    .WAIT_CYCLES(0),
    .BASE_ADDR  (32'h0000_1000)
  ) dut_b (
    .clk(clk), .reset(reset), .memory_addr(b_addr), .memory_rden(b_rden),
    .memory_wren(b_wren), .memory_write_val(b_wval), .memory_read_val(b_rval),
    .memory_response(b_resp), .memory_error(b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m0 [256];
  bit          k0 [256];
  logic [31:0] m1 [16];
  bit          k1 [16];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] val;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      a_rden = rd; a_wren = wr; a_addr = addr; a_wval = wdata;
    end else begin
      b_rden = rd; b_wren = wr; b_addr = addr; b_wval = wdata;
    end
  endtask

  function automatic logic get_resp(input int sel);
    return (sel == 0) ? a_resp : b_resp;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? a_err : b_err;
  endfunction
  function automatic logic [31:0] get_val(input int sel);
    return (sel == 0) ? a_rval : b_rval;
  endfunction

  // One request held until its response; checks latency, flags, data and pulse width.
  task automatic transact(input int sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_val,
                          input bit chk_val, input string name);
    int lat;
    int wc;
    wc = (sel == 0) ? 2 : 0;
    @(negedge clk);
    drive(sel, rd, wr, addr, wdata);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!get_resp(sel) && lat < 40);
    drive(sel, 1'b0, 1'b0, '0, '0);
    check({name, " latency"}, 32'(lat), 32'(wc + 1));
    check({name, " error"}, 32'(get_err(sel)), 32'(exp_err));
    if (chk_val) check({name, " rdata"}, get_val(sel), exp_val);
    @(negedge clk);
    check({name, " pulse_end"}, 32'(get_resp(sel)), 32'd0);
    check({name, " err_low"}, 32'(get_err(sel)), 32'd0);
    if (chk_val) check({name, " rdata_hold"}, get_val(sel), exp_val);
  endtask

  function automatic logic ref_err(input int sel, input logic rd, input logic wr, input logic [31:0] addr);
    longint unsigned a, base, depth;
    a     = longint'(addr);
    base  = (sel == 0) ? 64'h0 : 64'h1000;
    depth = (sel == 0) ? 64'd256 : 64'd16;
    if (a % 4 != 0) return 1'b1;
    if (a < base) return 1'b1;
    if ((a - base) / 4 >= depth) return 1'b1;
    return rd && wr;
  endfunction

  task automatic model_req(input int sel, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata, input string name);
    logic        e;
    logic [31:0] ev;
    bit          chk;
    int          idx;
    e   = ref_err(sel, rd, wr, addr);
    idx = 0;
    if (!e) idx = int'((longint'(addr) - ((sel == 0) ? 64'h0 : 64'h1000)) / 4);
    ev  = '0;
    chk = 1'b1;
    if (!e && rd) begin
      chk = (sel == 0) ? k0[idx] : k1[idx];
      ev  = (sel == 0) ? m0[idx] : m1[idx];
    end
    transact(sel, rd, wr, addr, wdata, e, ev, chk, name);
    if (!e && wr) begin
      if (sel == 0) begin m0[idx] = wdata; k0[idx] = 1'b1; end
      else          begin m1[idx] = wdata; k1[idx] = 1'b1; end
    end
  endtask

  initial begin
    logic        r0 [5];
    logic [31:0] v0 [5];
    int          hit;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0020, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0000};
    tbl[8]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0020};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h8765_4321, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h8765_4321};
    tbl[12] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 32'h0000_0030, 32'h1111_1111, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b1, 32'h0000_0002, 32'h5555_5555, 1'b1, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'h1111_1111};

    for (int i = 0; i < 256; i++) k0[i] = 1'b0;
    for (int i = 0; i < 16; i++) k1[i] = 1'b0;

    repeat (3) @(negedge clk);
    check("reset a_resp", 32'(a_resp), 32'd0);
    check("reset a_err", 32'(a_err), 32'd0);
    check("reset a_rval", a_rval, 32'd0);
    check("reset b_resp", 32'(b_resp), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      transact(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
               tbl[i].err, tbl[i].val, 1'b1, $sformatf("vec%0d", i));
      if (tbl[i].wr && !tbl[i].err) begin
        m0[tbl[i].addr[9:2]] = tbl[i].wdata;
        k0[tbl[i].addr[9:2]] = 1'b1;
      end
    end

    // Reset during WAIT must drop the pending write and never respond.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h0000_0030, 32'h1234_5678);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    check("midreset rval", a_rval, 32'd0);
    hit = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_resp || a_err) hit++;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (a_resp || a_err) hit++;
    end
    check("midreset no_response", 32'(hit), 32'd0);
    model_req(0, 1'b1, 1'b0, 32'h0000_0030, '0, "midreset readback");

    // Zero wait states: back-to-back reads, one dead cycle between them.
    model_req(1, 1'b0, 1'b1, 32'h0000_1000, 32'h0BAD_F00D, "b w0");
    model_req(1, 1'b0, 1'b1, 32'h0000_1004, 32'h600D_CAFE, "b w1");
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h0000_1000, '0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      r0[c] = b_resp;
      v0[c] = b_rval;
      if (c == 1) drive(1, 1'b1, 1'b0, 32'h0000_1004, '0);
      if (c == 3) drive(1, 1'b0, 1'b0, '0, '0);
    end
    check("b2b resp c1", 32'(r0[1]), 32'd1);
    check("b2b resp c2", 32'(r0[2]), 32'd0);
    check("b2b resp c3", 32'(r0[3]), 32'd1);
    check("b2b resp c4", 32'(r0[4]), 32'd0);
    check("b2b data c1", v0[1], 32'h0BAD_F00D);
    check("b2b data c3", v0[3], 32'h600D_CAFE);

    model_req(1, 1'b1, 1'b0, 32'h0000_0FFC, '0, "b below_base");
    model_req(1, 1'b1, 1'b0, 32'h0000_1040, '0, "b past_end");
    model_req(1, 1'b0, 1'b1, 32'h0000_103C, 32'h7777_0001, "b last_w");
    model_req(1, 1'b1, 1'b0, 32'h0000_103C, '0, "b last_r");

    for (int i = 0; i < 120; i++) begin
      int          sel;
      int          kind;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] base;
      sel  = i % 2;
      base = (sel == 0) ? 32'h0 : 32'h1000;
      kind = $urandom_range(0, 9);
      wr   = $urandom_range(0, 1) == 1;
      rd   = !wr;
      addr = base + 32'($urandom_range(0, 15) * 4);
      case (kind)
        0: addr = addr + 32'($urandom_range(1, 3));
        1: addr = base + 32'((sel == 0) ? 1024 : 64) + 32'($urandom_range(0, 255) * 4);
        2: addr = (sel == 0) ? 32'hFFFF_FF00 : 32'h0000_0F00;
        3: begin rd = 1'b1; wr = 1'b1; end
        default: ;
      endcase
      model_req(sel, rd, wr, addr, $urandom(), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
